// File: rtl/tlu_pkg.sv
// Shared types and helpers for the TLU trigger-number receiver and related checkers.
package tlu_pkg;

    localparam int MIN_DELAY_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_CLOCK,
        ST_WAIT_LATCH,
        ST_LATCH,
        ST_PUBLISH,
        ST_WAIT_SAVE,
        ST_DONE
    } state_t;

    // A bit count of zero, or one the shift register cannot hold, means "full width".
    function automatic int clamp_bits(input int n, input int max_bits);
        return (n <= 0 || n > max_bits) ? max_bits : n;
    endfunction

endpackage

// File: rtl/tlu_bit_extract.sv
// Selects the N newest bits of the TLU shift register, optionally bit-reversed,
// and zero-extends them to the full word width.
module tlu_bit_extract #(
    parameter  int MAX_BITS = 32,
    localparam int CW       = $clog2(MAX_BITS + 1),
    localparam int IW       = $clog2(MAX_BITS)
) (
    input  logic [MAX_BITS-1:0] i_sr,
    input  logic [CW-1:0]       i_n,
    input  logic                i_msb_first,
    output logic [MAX_BITS-1:0] o_word
);

    logic [IW-1:0] w_idx;

    // NOTE: every variable written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        o_word = '0;
        w_idx  = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            if (CW'(i) < i_n) begin
                // sr[N-1] is the first bit received; LSB-first mode maps it to word[0].
                w_idx     = IW'(i_n - CW'(1) - CW'(i));
                o_word[i] = i_msb_first ? i_sr[i] : i_sr[w_idx];
            end
        end
    end

endmodule

// File: rtl/tlu_trigger_data_receiver.sv
// TLU serial trigger-number receiver: gates the TLU clock for N bits, latches the
// shifted-in word after the cable delay and offers it with a save handshake and timeout.
module tlu_trigger_data_receiver
    import tlu_pkg::*;
#(
    parameter  int MAX_BITS      = 32,
    parameter  int DELAY_WIDTH   = 4,
    parameter  int MIN_DELAY     = MIN_DELAY_DEFAULT,
    parameter  int TIMEOUT_WIDTH = 16,
    localparam int CW            = $clog2(MAX_BITS + 1)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [CW-1:0]            CONF_CLOCK_CYCLES,
    input  logic [DELAY_WIDTH-1:0]   CONF_DATA_DELAY,
    input  logic                     CONF_MSB_FIRST,
    input  logic [TIMEOUT_WIDTH-1:0] CONF_TIMEOUT,
    input  logic                     TLU_TRIGGER,
    input  logic                     TLU_RECEIVE_DATA_FLAG,
    output logic                     TLU_CLOCK_ENABLE,
    output logic                     TLU_DATA_RECEIVED_FLAG,
    output logic [MAX_BITS-1:0]      TLU_DATA,
    output logic                     TLU_DATA_VALID,
    output logic                     TLU_DATA_SAVE_FLAG,
    input  logic                     TLU_DATA_SAVED_FLAG,
    output logic                     TIMEOUT_FLAG,
    output logic [7:0]               TIMEOUT_COUNT
);

    localparam int DLY_W = $clog2((2 ** DELAY_WIDTH) + MIN_DELAY);

    state_t                   r_state;
    state_t                   w_state_next;

    logic [CW-1:0]            r_bit_cnt,  w_bit_cnt_next;
    logic [DLY_W-1:0]         r_dly_cnt,  w_dly_cnt_next;
    logic [TIMEOUT_WIDTH-1:0] r_wait_cnt, w_wait_cnt_next;
    logic [MAX_BITS-1:0]      r_data,     w_data_next;
    logic                     w_load_cfg;
    logic                     w_timeout;

    logic [CW-1:0]            r_n;
    logic [DELAY_WIDTH-1:0]   r_d;
    logic                     r_msb;
    logic [TIMEOUT_WIDTH-1:0] r_t;

    logic [MAX_BITS-1:0]      r_sr;
    logic [MAX_BITS-1:0]      w_word;
    logic [DLY_W-1:0]         w_dly_total;

    logic                     r_clk_en;
    logic                     r_valid;
    logic                     r_save;
    logic                     r_recv;
    logic                     r_tflag;
    logic [7:0]               r_tcnt;

    assign w_dly_total = DLY_W'(r_d) + DLY_W'(MIN_DELAY);

    tlu_bit_extract #(
        .MAX_BITS   (MAX_BITS)
    ) u_extract (
        .i_sr       (r_sr),
        .i_n        (r_n),
        .i_msb_first(r_msb),
        .o_word     (w_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_bit_cnt_next  = r_bit_cnt;
        w_dly_cnt_next  = r_dly_cnt;
        w_wait_cnt_next = r_wait_cnt;
        w_data_next     = '0;
        w_load_cfg      = 1'b0;
        w_timeout       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (TLU_RECEIVE_DATA_FLAG) begin
                    w_load_cfg     = 1'b1;
                    w_bit_cnt_next = '0;
                    w_state_next   = ST_SEND_CLOCK;
                end
            end
            ST_SEND_CLOCK: begin
                if (r_bit_cnt == r_n - CW'(1)) begin
                    w_dly_cnt_next = '0;
                    w_state_next   = ST_WAIT_LATCH;
                end else begin
                    w_bit_cnt_next = r_bit_cnt + CW'(1);
                end
            end
            ST_WAIT_LATCH: begin
                // Compare against count+1 so a zero total delay still exits after one cycle.
                if (r_dly_cnt + DLY_W'(1) >= w_dly_total) begin
                    w_state_next = ST_LATCH;
                end else begin
                    w_dly_cnt_next = r_dly_cnt + DLY_W'(1);
                end
            end
            ST_LATCH: begin
                w_data_next     = w_word;
                w_wait_cnt_next = '0;
                w_state_next    = ST_PUBLISH;
            end
            ST_PUBLISH, ST_WAIT_SAVE: begin
                if (TLU_DATA_SAVED_FLAG) begin
                    w_state_next = ST_DONE;
                end else if (r_t != '0 && r_wait_cnt == r_t - TIMEOUT_WIDTH'(1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_data_next     = r_data;
                    w_wait_cnt_next = r_wait_cnt + TIMEOUT_WIDTH'(1);
                    w_state_next    = ST_WAIT_SAVE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: the shift register is a plain register, not a memory, so it is cleared by
    // reset along with everything else and reset values never leak into a word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_dly_cnt  <= '0;
            r_wait_cnt <= '0;
            r_n        <= '0;
            r_d        <= '0;
            r_msb      <= 1'b0;
            r_t        <= '0;
            r_data     <= '0;
            r_clk_en   <= 1'b0;
            r_valid    <= 1'b0;
            r_save     <= 1'b0;
            r_recv     <= 1'b0;
            r_tflag    <= 1'b0;
            r_tcnt     <= '0;
        end else begin
            r_sr       <= {r_sr[MAX_BITS-2:0], TLU_TRIGGER};
            r_bit_cnt  <= w_bit_cnt_next;
            r_dly_cnt  <= w_dly_cnt_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_load_cfg) begin
                r_n   <= CW'(clamp_bits(int'(CONF_CLOCK_CYCLES), MAX_BITS));
                r_d   <= CONF_DATA_DELAY;
                r_msb <= CONF_MSB_FIRST;
                r_t   <= CONF_TIMEOUT;
            end
            r_data   <= w_data_next;
            r_clk_en <= (w_state_next == ST_SEND_CLOCK);
            r_valid  <= (w_state_next == ST_PUBLISH) || (w_state_next == ST_WAIT_SAVE);
            r_save   <= (w_state_next == ST_PUBLISH);
            r_recv   <= (w_state_next == ST_DONE);
            r_tflag  <= w_timeout;
            if (w_timeout && r_tcnt != 8'hFF) begin
                r_tcnt <= r_tcnt + 8'd1;
            end
        end
    end

    assign TLU_CLOCK_ENABLE       = r_clk_en;
    assign TLU_DATA_RECEIVED_FLAG = r_recv;
    assign TLU_DATA               = r_data;
    assign TLU_DATA_VALID         = r_valid;
    assign TLU_DATA_SAVE_FLAG     = r_save;
    assign TIMEOUT_FLAG           = r_tflag;
    assign TIMEOUT_COUNT          = r_tcnt;

endmodule

// File: tb/tb_tlu_trigger_data_receiver.sv
// Bench for tlu_trigger_data_receiver: a delayed-line TLU model feeds the serial line,
// a scoreboard holds the expected word/timeout per request.
module tb_tlu_trigger_data_receiver;

    localparam int MAX_BITS  = 32;
    localparam int MIN_DELAY = 4;
    localparam int CW        = 6;

    logic            CLK;
    logic            RESET;
    logic [CW-1:0]   CONF_CLOCK_CYCLES;
    logic [3:0]      CONF_DATA_DELAY;
    logic            CONF_MSB_FIRST;
    logic [15:0]     CONF_TIMEOUT;
    logic            TLU_TRIGGER;
    logic            TLU_RECEIVE_DATA_FLAG;
    logic            TLU_CLOCK_ENABLE;
    logic            TLU_DATA_RECEIVED_FLAG;
    logic [31:0]     TLU_DATA;
    logic            TLU_DATA_VALID;
    logic            TLU_DATA_SAVE_FLAG;
    logic            TLU_DATA_SAVED_FLAG;
    logic            TIMEOUT_FLAG;
    logic [7:0]      TIMEOUT_COUNT;

    tlu_trigger_data_receiver dut (
        .CLK                   (CLK),
        .RESET                 (RESET),
        .CONF_CLOCK_CYCLES     (CONF_CLOCK_CYCLES),
        .CONF_DATA_DELAY       (CONF_DATA_DELAY),
        .CONF_MSB_FIRST        (CONF_MSB_FIRST),
        .CONF_TIMEOUT          (CONF_TIMEOUT),
        .TLU_TRIGGER           (TLU_TRIGGER),
        .TLU_RECEIVE_DATA_FLAG (TLU_RECEIVE_DATA_FLAG),
        .TLU_CLOCK_ENABLE      (TLU_CLOCK_ENABLE),
        .TLU_DATA_RECEIVED_FLAG(TLU_DATA_RECEIVED_FLAG),
        .TLU_DATA              (TLU_DATA),
        .TLU_DATA_VALID        (TLU_DATA_VALID),
        .TLU_DATA_SAVE_FLAG    (TLU_DATA_SAVE_FLAG),
        .TLU_DATA_SAVED_FLAG   (TLU_DATA_SAVED_FLAG),
        .TIMEOUT_FLAG          (TIMEOUT_FLAG),
        .TIMEOUT_COUNT         (TIMEOUT_COUNT)
    );

    typedef struct {
        logic [31:0] word;
        bit          timeout;
    } exp_t;

    exp_t        sb[$];
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          exp_tcnt  = 0;
    logic [31:0] tx_stream = '0;
    int          lat       = 5;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Word the receiver must produce from stream bits s[0..n-1] (s[0] sent first).
    function automatic logic [31:0] model_word(input logic [31:0] s, input int n, input bit msb);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < n; k++) begin
            w = w | (32'(s[k]) << (msb ? (n - 1 - k) : k));
        end
        return w;
    endfunction

    // Serial stream that sends the n-bit value val MSB first.
    function automatic logic [31:0] msb_stream(input logic [31:0] val, input int n);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < n; k++) begin
            s = s | (((val >> (n - 1 - k)) & 32'd1) << k);
        end
        return s;
    endfunction

    // TLU model: each gated clock cycle emits the next stream bit, which reaches
    // TLU_TRIGGER after 'lat' cycles of cable/synchroniser latency; idle line reads 1.
    initial begin : tlu_model
        logic dl [0:31];
        int   idx;
        for (int i = 0; i < 32; i++) dl[i] = 1'b1;
        idx         = 0;
        TLU_TRIGGER = 1'b1;
        forever begin
            @(negedge CLK);
            for (int i = 31; i > 0; i--) dl[i] = dl[i-1];
            if (TLU_CLOCK_ENABLE) begin
                dl[0] = tx_stream[idx[4:0]];
                idx++;
            end else begin
                dl[0] = 1'b1;
                idx   = 0;
            end
            TLU_TRIGGER = dl[lat-1];
        end
    end

    initial begin : monitor
        exp_t cur;
        bit   has_cur;
        has_cur = 1'b0;
        forever begin
            @(negedge CLK);
            if (TLU_DATA_SAVE_FLAG) begin
                if (sb.size() == 0) begin
                    check("save_without_request", 1, 0);
                end else begin
                    cur     = sb.pop_front();
                    has_cur = 1'b1;
                    check("data_word", TLU_DATA, cur.word);
                    check("valid_with_save", TLU_DATA_VALID, 1);
                end
            end
            if (TLU_DATA_RECEIVED_FLAG) begin
                if (!has_cur) begin
                    check("received_without_word", 1, 0);
                end else begin
                    check("timeout_flag", TIMEOUT_FLAG, cur.timeout);
                    check("done_clears_data", {TLU_DATA_VALID, TLU_DATA}, 0);
                    has_cur = 1'b0;
                end
            end else if (TIMEOUT_FLAG) begin
                check("stray_timeout_flag", 1, 0);
            end
        end
    end

    task automatic do_txn(input int n_cfg, input int d, input bit msb, input int t,
                          input logic [31:0] stream, input int ack_at, input bit toggle);
        int   n_eff, exp_valid, exp_first, c, vidx, first_v, recv_c, ce_cnt, save_cnt, idle_ce;
        bit   exp_to, done;
        exp_t e;
        n_eff     = (n_cfg == 0 || n_cfg > MAX_BITS) ? MAX_BITS : n_cfg;
        exp_to    = (t != 0) && (ack_at < 0 || ack_at > t - 1);
        exp_valid = exp_to ? t : ack_at + 1;
        exp_first = n_eff + d + MIN_DELAY + 1;
        if (exp_to && exp_tcnt < 255) exp_tcnt++;
        e.word    = model_word(stream, n_eff, msb);
        e.timeout = exp_to;

        @(negedge CLK);
        CONF_CLOCK_CYCLES     = CW'(n_cfg);
        CONF_DATA_DELAY       = 4'(d);
        CONF_MSB_FIRST        = msb;
        CONF_TIMEOUT          = 16'(t);
        tx_stream             = stream;
        lat                   = d + MIN_DELAY + 1;
        TLU_RECEIVE_DATA_FLAG = 1'b1;
        sb.push_back(e);

        c = 0; done = 1'b0; vidx = 0; first_v = -1; recv_c = -1; ce_cnt = 0; save_cnt = 0;
        while (!done && c < 400) begin
            @(negedge CLK);
            if (c == 0) begin
                // Latched config must be immune to later changes.
                CONF_CLOCK_CYCLES = CW'($urandom);
                CONF_DATA_DELAY   = 4'($urandom);
                CONF_MSB_FIRST    = ~msb;
                CONF_TIMEOUT      = 16'($urandom_range(1, 3));
            end
            if (TLU_CLOCK_ENABLE)   ce_cnt++;
            if (TLU_DATA_SAVE_FLAG) save_cnt++;
            if (TLU_DATA_VALID) begin
                if (first_v < 0) first_v = c;
                TLU_DATA_SAVED_FLAG   = (vidx == ack_at);
                TLU_RECEIVE_DATA_FLAG = toggle && vidx >= 3 && vidx <= 6 && (vidx % 2 == 1);
                vidx++;
            end else begin
                TLU_DATA_SAVED_FLAG   = 1'b0;
                TLU_RECEIVE_DATA_FLAG = 1'b0;
            end
            if (TLU_DATA_RECEIVED_FLAG) begin
                done   = 1'b1;
                recv_c = c;
            end
            c++;
        end
        TLU_DATA_SAVED_FLAG   = 1'b0;
        TLU_RECEIVE_DATA_FLAG = 1'b0;

        check("done_seen", done, 1);
        check("clock_enable_cycles", ce_cnt, n_eff);
        check("first_valid_cycle", first_v, exp_first);
        check("valid_cycles", vidx, exp_valid);
        check("save_pulses", save_cnt, 1);
        check("received_cycle", recv_c, exp_first + exp_valid);
        check("timeout_count", TIMEOUT_COUNT, exp_tcnt);
        if (toggle) begin
            idle_ce = 0;
            repeat (10) begin
                @(negedge CLK);
                idle_ce += int'(TLU_CLOCK_ENABLE);
            end
            check("no_restart_after_toggle", idle_ce, 0);
        end
    endtask

    initial begin : main
        int pulses;
        RESET                 = 1'b1;
        CONF_CLOCK_CYCLES     = '0;
        CONF_DATA_DELAY       = '0;
        CONF_MSB_FIRST        = 1'b0;
        CONF_TIMEOUT          = '0;
        TLU_RECEIVE_DATA_FLAG = 1'b0;
        TLU_DATA_SAVED_FLAG   = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_clock_enable", TLU_CLOCK_ENABLE, 0);
        check("rst_received", TLU_DATA_RECEIVED_FLAG, 0);
        check("rst_data", TLU_DATA, 0);
        check("rst_valid", TLU_DATA_VALID, 0);
        check("rst_save", TLU_DATA_SAVE_FLAG, 0);
        check("rst_timeout_flag", TIMEOUT_FLAG, 0);
        check("rst_timeout_count", TIMEOUT_COUNT, 0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        do_txn(16, 0, 1'b1, 0,  msb_stream(32'hA5C3, 16), 0,  1'b0);
        do_txn(16, 0, 1'b0, 0,  msb_stream(32'hA5C3, 16), 0,  1'b0);
        do_txn(0,  3, 1'b1, 0,  $urandom,                 2,  1'b0);
        do_txn(45, 2, 1'b0, 0,  $urandom,                 1,  1'b0);
        do_txn(5,  7, 1'b0, 0,  $urandom,                 25, 1'b0);
        do_txn(8,  1, 1'b1, 10, $urandom,                 -1, 1'b0);
        do_txn(8,  1, 1'b0, 10, $urandom,                 9,  1'b0);
        do_txn(1,  0, 1'b1, 1,  $urandom,                 0,  1'b0);
        do_txn(12, 2, 1'b1, 0,  $urandom,                 20, 1'b1);
        for (int r = 0; r < 300; r++) begin
            do_txn(1, 0, 1'b1, 1, $urandom, -1, 1'b0);
        end
        check("timeout_count_saturated", TIMEOUT_COUNT, 255);

        // Reset in the middle of the gated clock burst.
        @(negedge CLK);
        CONF_CLOCK_CYCLES     = CW'(32);
        CONF_DATA_DELAY       = 4'd0;
        CONF_TIMEOUT          = 16'd0;
        tx_stream             = $urandom;
        lat                   = MIN_DELAY + 1;
        TLU_RECEIVE_DATA_FLAG = 1'b1;
        @(negedge CLK);
        TLU_RECEIVE_DATA_FLAG = 1'b0;
        repeat (4) @(negedge CLK);
        check("clock_enable_before_reset", TLU_CLOCK_ENABLE, 1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET    = 1'b0;
        exp_tcnt = 0;
        check("abort_clock_enable", TLU_CLOCK_ENABLE, 0);
        check("abort_received", TLU_DATA_RECEIVED_FLAG, 0);
        check("abort_data", TLU_DATA, 0);
        check("abort_valid", TLU_DATA_VALID, 0);
        check("abort_save", TLU_DATA_SAVE_FLAG, 0);
        check("abort_timeout_flag", TIMEOUT_FLAG, 0);
        check("abort_timeout_count", TIMEOUT_COUNT, 0);
        pulses = 0;
        repeat (60) begin
            @(negedge CLK);
            pulses += int'(TLU_CLOCK_ENABLE | TLU_DATA_VALID | TLU_DATA_SAVE_FLAG |
                           TLU_DATA_RECEIVED_FLAG | TIMEOUT_FLAG);
        end
        check("no_activity_after_abort", pulses, 0);

        do_txn(16, 0, 1'b1, 0, msb_stream(32'hA5C3, 16), 0, 1'b0);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tlu_trigger_data_receiver.md
Name: tlu_trigger_data_receiver

Overview:
Parametrised successor of the TLU serial trigger-number receiver. Gates the TLU clock for a configurable number of bits and samples the serial TLU_TRIGGER line into a MAX_BITS shift register. Extracts the N received bits with selectable bit order, then presents the word to the trigger/data-save logic with a save handshake that has a timeout. Sits between the TLU input synchroniser and the trigger FIFO writer.

Parameters:
MAX_BITS, 32, maximum trigger-number width; shift-register and TLU_DATA width.
DELAY_WIDTH, 4, width of CONF_DATA_DELAY.
MIN_DELAY, 4, fixed minimum latch delay in cycles, covering cable and synchroniser latency.
TIMEOUT_WIDTH, 16, width of CONF_TIMEOUT and the save-wait counter.
CW, clog2(MAX_BITS+1), derived localparam; width of CONF_CLOCK_CYCLES and the bit counter.

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
CONF_CLOCK_CYCLES  in  CW  bits to receive, N; 0 or greater than MAX_BITS means MAX_BITS
CONF_DATA_DELAY  in  DELAY_WIDTH  extra latch delay D
CONF_MSB_FIRST  in  1  1 = first received bit is the MSB
CONF_TIMEOUT  in  TIMEOUT_WIDTH  save-wait limit T in cycles; 0 disables the timeout
TLU_TRIGGER  in  1  serial data, already synchronised to CLK
TLU_RECEIVE_DATA_FLAG  in  1  start request
TLU_CLOCK_ENABLE  out  1  TLU clock gate
TLU_DATA_RECEIVED_FLAG  out  1  1-cycle done pulse
TLU_DATA  out  MAX_BITS  received word, zero-extended
TLU_DATA_VALID  out  1  level, high while TLU_DATA is offered
TLU_DATA_SAVE_FLAG  out  1  1-cycle pulse on the first valid cycle
TLU_DATA_SAVED_FLAG  in  1  consumer acknowledge
TIMEOUT_FLAG  out  1  1-cycle pulse when a word is dropped
TIMEOUT_COUNT  out  8  saturating count of dropped words

Behaviour:
- All outputs are registered. On RESET, every output, the counters and the shift register go to 0 and the FSM goes to IDLE on the next edge. A reset in any state aborts the operation with no pulses issued.
- Shift register: sr <= {sr[MAX_BITS-2:0], TLU_TRIGGER} on every cycle except reset. sr[0] is the newest bit.
- FSM states: IDLE, SEND_CLOCK, WAIT_LATCH, LATCH, PUBLISH, WAIT_SAVE, DONE.
- IDLE:
  - When TLU_RECEIVE_DATA_FLAG is sampled high, latch N, D, MSB_FIRST and T into internal registers and go to SEND_CLOCK.
  - Config changes after this point have no effect until the next request.
  - TLU_RECEIVE_DATA_FLAG is ignored in every other state.
- SEND_CLOCK: TLU_CLOCK_ENABLE is high for exactly N cycles, then go to WAIT_LATCH.
- WAIT_LATCH: TLU_CLOCK_ENABLE is low; wait D+MIN_DELAY cycles, then go to LATCH.
- LATCH: one cycle; capture the extracted word.
  - MSB_FIRST=1: word = sr[N-1:0].
  - MSB_FIRST=0: word[i] = sr[N-1-i] for i<N.
  - In both cases bits N and above are 0.
- PUBLISH/WAIT_SAVE:
  - TLU_DATA = word and TLU_DATA_VALID=1 from the PUBLISH cycle until exit.
  - TLU_DATA_SAVE_FLAG=1 only in the PUBLISH cycle.
  - TLU_DATA_SAVED_FLAG is honoured when sampled high in any cycle with VALID high, including PUBLISH. This exits to DONE.
  - The wait counter starts at 0 in PUBLISH and increments each cycle.
  - If T!=0 and the counter reaches T-1 with no acknowledge: TIMEOUT_FLAG pulses, TIMEOUT_COUNT increments (saturating at 255), then go to DONE.
  - If the acknowledge and the timeout occur in the same cycle, the acknowledge wins and there is no timeout.
- DONE: one cycle; TLU_DATA_RECEIVED_FLAG=1, TLU_DATA=0, VALID=0, then go to IDLE.
- Timing: with the request sampled at edge t, CLOCK_ENABLE is high after edges t..t+N-1. VALID and SAVE_FLAG first go high after edge t+N+D+MIN_DELAY+1.

Decomposition:
- Package tlu_pkg holds the state enum, the MIN_DELAY default, and a clamp function that maps N=0 or N>MAX_BITS to MAX_BITS.
- One sub-module, tlu_bit_extract: combinational N-bit selection, bit reversal and zero-extension from sr. It is parametrised by MAX_BITS and is reusable by the trigger-number checker.

Test Plan:
- N=16, D=0, MSB_FIRST=1, serial 0xA5C3 sent MSB first, acknowledge in the PUBLISH cycle -> TLU_DATA=0x0000A5C3; SAVE_FLAG pulses once; RECEIVED_FLAG pulses one cycle later.
- N=16, MSB_FIRST=0, same bit stream -> TLU_DATA=0x0000C3A5 (bit-reversed 0xA5C3).
- N=0 (treated as 32), D=3 -> CLOCK_ENABLE high exactly 32 cycles; VALID high after edge t+32+3+4+1.
- T=10 and acknowledge never asserted -> TIMEOUT_FLAG pulses on cycle 10 of VALID; RECEIVED_FLAG pulses; TIMEOUT_COUNT=1. After 300 repeats TIMEOUT_COUNT=255.
- Acknowledge high in the same cycle the counter reaches T-1 -> no TIMEOUT_FLAG; TIMEOUT_COUNT unchanged.
- RESET asserted mid-SEND_CLOCK, and separately RECEIVE_DATA_FLAG toggled during WAIT_SAVE -> after reset all outputs are 0 and the FSM is in IDLE with no pulses; the toggle during WAIT_SAVE causes no restart.
